// File: rtl/lsu_if.sv
// Handshake and data-memory bus between the execute stage, the LSU and the memory.
interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        err;

    modport slave (
        input  req_valid, is_store, funct3, addr, store_data, mem_gnt, mem_rvalid, mem_rdata,
        output req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata, resp_valid, resp_data,
               err
    );

    modport master (
        output req_valid, is_store, funct3, addr, store_data, mem_gnt, mem_rvalid, mem_rdata,
        input  req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata, resp_valid, resp_data,
               err
    );
endinterface

// File: rtl/lsu.sv
// RV32I load/store unit: one op in flight, lane shifting for stores and extension for loads.
module lsu (
    input logic  clk,
    input logic  rst_n,
    lsu_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

    state_e      state_q;
    logic [2:0]  funct3_q;
    logic [1:0]  offset_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [3:0]  mem_be_q;
    logic [31:0] mem_wdata_q;
    logic        resp_valid_q;
    logic [31:0] resp_data_q;
    logic        err_q;

    logic        illegal;
    logic        misaligned;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [31:0] lane;
    logic [31:0] load_ext;

    // Decode of the op presented in IDLE.
    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        be_d       = 4'b1111;
        wdata_d    = bus.store_data;
        case (bus.funct3)
            3'b000, 3'b100: begin
                be_d    = 4'b0001 << bus.addr[1:0];
                wdata_d = {4{bus.store_data[7:0]}};
            end
            3'b001, 3'b101: begin
                misaligned = bus.addr[0];
                be_d       = 4'b0011 << bus.addr[1:0];
                wdata_d    = {2{bus.store_data[15:0]}};
            end
            3'b010:  misaligned = |bus.addr[1:0];
            default: illegal = 1'b1;
        endcase
        if (bus.funct3[2] && bus.is_store) begin
            illegal = 1'b1;
        end
    end

    always_comb begin
        lane = bus.mem_rdata >> {offset_q, 3'b000};
        case (funct3_q)
            3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
            3'b100:  load_ext = {24'b0, lane[7:0]};
            3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
            3'b101:  load_ext = {16'b0, lane[15:0]};
            default: load_ext = bus.mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            funct3_q     <= 3'b0;
            offset_q     <= 2'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'b0;
            mem_be_q     <= 4'b0;
            mem_wdata_q  <= 32'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 32'b0;
            err_q        <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.req_valid) begin
                        funct3_q <= bus.funct3;
                        offset_q <= bus.addr[1:0];
                        if (illegal || misaligned) begin
                            state_q      <= StResp;
                            resp_valid_q <= 1'b1;
                            resp_data_q  <= 32'b0;
                            err_q        <= 1'b1;
                        end else begin
                            state_q     <= StReq;
                            mem_we_q    <= bus.is_store;
                            mem_addr_q  <= {bus.addr[31:2], 2'b00};
                            mem_be_q    <= be_d;
                            mem_wdata_q <= wdata_d;
                        end
                    end
                end
                StReq: begin
                    if (bus.mem_gnt) begin
                        if (mem_we_q) begin
                            state_q      <= StResp;
                            resp_valid_q <= 1'b1;
                            resp_data_q  <= 32'b0;
                            err_q        <= 1'b0;
                        end else begin
                            state_q <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (bus.mem_rvalid) begin
                        state_q      <= StResp;
                        resp_valid_q <= 1'b1;
                        resp_data_q  <= load_ext;
                        err_q        <= 1'b0;
                    end
                end
                StResp: begin
                    state_q      <= StIdle;
                    resp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready  = (state_q == StIdle);
    assign bus.mem_req    = (state_q == StReq);
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_be     = mem_be_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_lsu.sv
// Randomized bench for lsu: a transaction-level model sets per-cycle expectations that a
// negedge compare process checks, plus literal pins from hand-worked examples.
module tb_lsu;
    logic clk = 1'b0;
    logic rst_n;

    lsu_if bus ();

    lsu dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    bit          chk_en = 1'b0;
    bit          exp_ready, exp_mreq, exp_we, exp_rv, exp_err;
    logic [31:0] exp_addr, exp_wdata, exp_data;
    logic [3:0]  exp_be;
    logic [31:0] hold_data;
    bit          hold_err;

    int          obs_req_cycles = 0;
    int          obs_resp_cnt = 0;
    logic [31:0] obs_addr, obs_wdata, obs_data;
    logic [3:0]  obs_be;
    logic        obs_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, required %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int op_size(input logic [2:0] f);
        case (f)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic bit op_err(input bit st, input logic [2:0] f, input logic [31:0] a);
        int sz;
        sz = op_size(f);
        if (sz == 0 || (st && f >= 3'd4)) return 1'b1;
        return (int'(a[1:0]) % sz) != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f, input logic [31:0] a);
        logic [3:0] be;
        int off, sz;
        off = int'(a[1:0]);
        sz  = op_size(f);
        for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + sz);
        return be;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f, input logic [31:0] sd);
        logic [31:0] w;
        int sz;
        sz = op_size(f);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % sz) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f, input logic [31:0] a,
                                               input logic [31:0] rd);
        logic [31:0] v;
        int sz;
        sz = op_size(f);
        v  = rd >> (8 * int'(a[1:0]));
        if (sz < 4) begin
            v = v & ((32'h1 << (8 * sz)) - 32'h1);
            if (f < 3'd4 && v[8*sz-1]) v = v - (32'h1 << (8 * sz));
        end
        return v;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk1("req_ready", bus.req_ready, exp_ready);
            chk1("mem_req", bus.mem_req, exp_mreq);
            chk1("resp_valid", bus.resp_valid, exp_rv);
            if (exp_mreq) begin
                chk1("mem_we", bus.mem_we, exp_we);
                chk("mem_addr", bus.mem_addr, exp_addr);
                chk("mem_be", 32'(bus.mem_be), 32'(exp_be));
                if (exp_we) chk("mem_wdata", bus.mem_wdata, exp_wdata);
            end
            if (exp_rv) begin
                chk("resp_data", bus.resp_data, exp_data);
                chk1("err", bus.err, exp_err);
            end else begin
                chk("resp_data_hold", bus.resp_data, hold_data);
                chk1("err_hold", bus.err, hold_err);
            end
        end
        if (bus.mem_req) begin
            obs_req_cycles++;
            obs_addr  = bus.mem_addr;
            obs_be    = bus.mem_be;
            obs_wdata = bus.mem_wdata;
        end
        if (bus.resp_valid) begin
            obs_resp_cnt++;
            obs_data = bus.resp_data;
            obs_err  = bus.err;
        end
    end

    // ---------------- driver ----------------
    // Called and returns 1 time unit after a rising edge.
    task automatic run_op(input bit st, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] sd, input int gd, input int rd,
                          input bit early_rv, input logic [31:0] rdata);
        bit e;
        e = op_err(st, f, a);
        bus.req_valid  = 1'b1;
        bus.is_store   = st;
        bus.funct3     = f;
        bus.addr       = a;
        bus.store_data = sd;
        exp_ready = 1'b1;
        exp_mreq  = 1'b0;
        exp_rv    = 1'b0;
        @(posedge clk); #1;
        bus.req_valid  = 1'b0;
        bus.is_store   = 1'($urandom);
        bus.funct3     = 3'($urandom);
        bus.addr       = $urandom;
        bus.store_data = $urandom;
        exp_ready = 1'b0;
        if (e) begin
            exp_rv   = 1'b1;
            exp_err  = 1'b1;
            exp_data = 32'h0;
        end else begin
            exp_mreq  = 1'b1;
            exp_we    = st;
            exp_addr  = {a[31:2], 2'b00};
            exp_be    = model_be(f, a);
            exp_wdata = model_wdata(f, sd);
            for (int i = 0; i <= gd; i++) begin
                bus.mem_gnt    = (i == gd);
                bus.mem_rvalid = (i == gd) ? early_rv : 1'($urandom);
                bus.mem_rdata  = $urandom;
                @(posedge clk); #1;
            end
            bus.mem_gnt    = 1'b0;
            bus.mem_rvalid = 1'b0;
            exp_mreq       = 1'b0;
            if (!st) begin
                for (int i = 0; i <= rd; i++) begin
                    bus.mem_rvalid = (i == rd);
                    bus.mem_rdata  = (i == rd) ? rdata : $urandom;
                    @(posedge clk); #1;
                end
                bus.mem_rvalid = 1'b0;
            end
            exp_rv   = 1'b1;
            exp_err  = 1'b0;
            exp_data = st ? 32'h0 : model_load(f, a, rdata);
        end
        @(posedge clk); #1;
        exp_rv    = 1'b0;
        exp_ready = 1'b1;
        hold_data = exp_data;
        hold_err  = exp_err;
    endtask

    // Idle cycles with stray read-valid pulses that must be ignored.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus.mem_rvalid = 1'($urandom);
            bus.mem_rdata  = $urandom;
            @(posedge clk); #1;
        end
        bus.mem_rvalid = 1'b0;
    endtask

    int r0, c0;

    initial begin
        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.is_store   = 1'b0;
        bus.funct3     = 3'b0;
        bus.addr       = 32'h0;
        bus.store_data = 32'h0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        exp_ready = 1'b1; exp_mreq = 1'b0; exp_we = 1'b0; exp_rv = 1'b0; exp_err = 1'b0;
        exp_addr = 0; exp_wdata = 0; exp_data = 0; exp_be = 0;
        hold_data = 32'h0; hold_err = 1'b0;

        #3;
        chk1("rst_req_ready", bus.req_ready, 1'b1);
        chk1("rst_mem_req", bus.mem_req, 1'b0);
        chk1("rst_mem_we", bus.mem_we, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_be", 32'(bus.mem_be), 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        chk1("rst_resp_valid", bus.resp_valid, 1'b0);
        chk("rst_resp_data", bus.resp_data, 32'h0);
        chk1("rst_err", bus.err, 1'b0);

        @(posedge clk); #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // SW with grant after two cycles, accepted on first edge after reset release
        r0 = obs_req_cycles; c0 = obs_resp_cnt;
        run_op(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 2, 0, 1'b0, 32'h0);
        chk("sw_req_cycles", 32'(obs_req_cycles - r0), 32'd3);
        chk("sw_resp_cnt", 32'(obs_resp_cnt - c0), 32'd1);
        chk("sw_addr", obs_addr, 32'h100);
        chk("sw_be", 32'(obs_be), 32'hF);
        chk("sw_wdata", obs_wdata, 32'hDEADBEEF);
        chk1("sw_err", obs_err, 1'b0);

        run_op(1'b1, 3'b000, 32'h103, 32'h000000A5, 0, 0, 1'b0, 32'h0);
        chk("sb_addr", obs_addr, 32'h100);
        chk("sb_be", 32'(obs_be), 32'h8);
        chk("sb_wdata", obs_wdata, 32'hA5A5A5A5);

        run_op(1'b0, 3'b000, 32'h102, 32'h0, 0, 0, 1'b0, 32'h12F03456);
        chk("lb_data", obs_data, 32'hFFFFFFF0);
        run_op(1'b0, 3'b100, 32'h102, 32'h0, 1, 2, 1'b0, 32'h12F03456);
        chk("lbu_data", obs_data, 32'h000000F0);
        run_op(1'b0, 3'b001, 32'h102, 32'h0, 0, 1, 1'b0, 32'h12F03456);
        chk("lh_data", obs_data, 32'h000012F0);

        r0 = obs_req_cycles;
        run_op(1'b0, 3'b010, 32'h101, 32'h0, 0, 0, 1'b0, 32'h0);
        chk("lw_mis_req_cycles", 32'(obs_req_cycles - r0), 32'd0);
        chk1("lw_mis_err", obs_err, 1'b1);
        chk("lw_mis_data", obs_data, 32'h0);
        r0 = obs_req_cycles;
        run_op(1'b0, 3'b011, 32'h100, 32'h0, 0, 0, 1'b0, 32'h0);
        chk("f011_req_cycles", 32'(obs_req_cycles - r0), 32'd0);
        chk1("f011_err", obs_err, 1'b1);

        run_op(1'b0, 3'b010, 32'h200, 32'h0, 0, 1, 1'b1, 32'hCAFEF00D);
        chk("early_rvalid_data", obs_data, 32'hCAFEF00D);

        // Long stall in REQ
        run_op(1'b1, 3'b001, 32'h302, 32'h00001234, 20, 0, 1'b0, 32'h0);
        chk("sh_long_be", 32'(obs_be), 32'hC);
        chk("sh_long_wdata", obs_wdata, 32'h12341234);

        // Asynchronous reset in REQ, then in WAIT
        chk_en = 1'b0;
        bus.req_valid = 1'b1; bus.is_store = 1'b0; bus.funct3 = 3'b010; bus.addr = 32'h400;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk1("arst_req_mem_req", bus.mem_req, 1'b0);
        chk1("arst_req_ready", bus.req_ready, 1'b1);
        chk("arst_req_addr", bus.mem_addr, 32'h0);
        chk("arst_req_be", 32'(bus.mem_be), 32'h0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.mem_gnt   = 1'b1;
        @(posedge clk); #1;
        bus.mem_gnt = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk1("arst_wait_mem_req", bus.mem_req, 1'b0);
        chk1("arst_wait_ready", bus.req_ready, 1'b1);
        chk("arst_wait_resp_data", bus.resp_data, 32'h0);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = $urandom;
            @(negedge clk);
            chk1("post_rst_rvalid_ignored", bus.resp_valid, 1'b0);
        end
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b0;
        hold_data = 32'h0; hold_err = 1'b0;
        exp_ready = 1'b1; exp_mreq = 1'b0; exp_rv = 1'b0;
        chk_en = 1'b1;

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            logic [31:0] a;
            a = {20'h0, 12'($urandom)};
            run_op(1'($urandom), 3'($urandom), a, $urandom, int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), 1'($urandom), $urandom);
            idle(int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
